prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
// Writer side of the instruction memory: the CPU reads instrmem, this block fills it.
// Accepts a byte stream (valid/ready), assembles little-endian 32-bit words, writes them to the
// instrmem write port, holds the CPU in reset while loading, and releases it on a verified load.
// Sits between the host byte link (UART RX or testbench) and the top level beside cpu.
// PARAMETERS
// WIDTH      32    instruction/data word width
// DEPTH      1024  instrmem capacity in words; larger word counts are rejected
// BASE_ADDR  0     byte address of word 0 as written to instrmem
// PORTS
// clk         in   1      system clock
// rst         in   1      synchronous, active-high reset
// start       in   1      pulse: begin a new load (ignored while busy)
// rx_valid    in   1      rx_data holds a byte
// rx_data     in   8      stream byte
// rx_ready    out  1      loader accepts a byte this cycle
// imem_we     out  1      instrmem write strobe (one cycle per word)
// imem_addr   out  WIDTH  byte address, BASE_ADDR + 4*word_index
// imem_wdata  out  WIDTH  assembled instruction word
// cpu_hold    out  1      drives cpu rst (OR'd with system rst at top level)
// busy        out  1      load in progress (HDR..CSUM)
// done        out  1      one-cycle pulse on successful load
// error       out  1      sticky until next start or rst
// BEHAVIOUR
// - One clock (clk); reset synchronous, active-high (rst). Byte transfer = rx_valid & rx_ready.
// - Reset: state IDLE; rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0,
//   error=0, cpu_hold=1 (CPU stays held until first successful load). rst mid-load aborts at once.
// - Frame: 4-byte word count N (LE), then 4*N bytes (LE per word), then 1 checksum byte =
//   sum of all 4*N data bytes mod 256 (header bytes excluded).
// - States: IDLE -start-> HDR (cpu_hold=1, error=0, busy=1, sum=0, index=0).
//   HDR: rx_ready=1; after 4th byte: N==0 -> CSUM; N>DEPTH -> ERR; else DATA.
//   DATA: rx_ready=1; 4th byte of a word accepted in cycle n -> WRITE in n+1.
//   WRITE: imem_we=1, imem_addr=BASE_ADDR+4*index, imem_wdata=word; rx_ready=0; index++;
//     -> DATA if index+1<N, else CSUM. rx_ready back high in n+2.
//   CSUM: rx_ready=1; byte==sum -> DONE, else ERR.
//   DONE: done=1 for one cycle, busy=0; cpu_hold=0 from next cycle -> IDLE.
//   ERR: error=1, busy=0, rx_ready=0, cpu_hold stays 1 -> IDLE (error remains set).
// - start in any state other than IDLE ignored; start in the cycle of done ignored.
// - Bytes with rx_valid high while rx_ready low are not consumed (source holds them).
// - Checksum accumulator 8 bits, wraps mod 256; index counter clog2(DEPTH)+1 bits, no wrap (N<=DEPTH).
// - imem_addr/imem_wdata hold last value outside WRITE; only imem_we qualifies them.
// STRUCTURE
// - loader_pkg: state enum {IDLE,HDR,DATA,WRITE,CSUM,DONE,ERR}, HDR_BYTES=4, BYTES_PER_WORD=4.
// - Sub-module byte_assembler: 2-bit byte counter + 32-bit LE shift register, emits word_valid on
//   4th byte, clear input; reused for header count and data words.
// TESTING
// - rst held 2 cycles -> cpu_hold=1, rx_ready=0, imem_we=0, error=0; start then N=2, words
//   0x00500093,0x00100113, csum -> two imem_we at addr 0x0,0x4; done pulse; cpu_hold 0 next cycle.
// - N=0, checksum 0x00 -> no imem_we, done=1, cpu_hold released.
// - N=DEPTH+1 -> error=1 after 4th header byte, rx_ready=0, cpu_hold=1, no imem_we.
// - N=1, word 0x11223344, checksum 0xAB (correct 0xAA) -> one write, error=1, no done, hold=1.
// - rx_valid toggling every other cycle, N=3 -> same writes as gapless stream, one cycle rx_ready=0
//   after each 4th byte; start pulse mid-load ignored.
// - rst asserted after 6 data bytes, then full reload N=1 -> reset values restored, clean load,
//   imem_addr=BASE_ADDR for the single write.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

   localparam int HDR_BYTES      = 4;
   localparam int BYTES_PER_WORD = 4;

   // state     | meaning
   // IDLE      | waiting for start; CPU hold reflects outcome of last load
   // HDR       | collecting the 4-byte little-endian word count
   // DATA      | collecting the bytes of the current instruction word
   // WRITE     | one-cycle instrmem write of the assembled word
   // CSUM      | waiting for the checksum byte
   // DONE      | one-cycle success pulse, CPU released next cycle
   // ERR       | load rejected, error latched, CPU stays held
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

   // Index of the final byte of the field currently being assembled.
   function automatic logic [1:0] last_byte_idx(input state_t s);
      return (s == HDR) ? 2'(HDR_BYTES - 1) : 2'(BYTES_PER_WORD - 1);
   endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Gathers a little-endian word from a byte stream; shared by the header
// count and the instruction words.
module prog_loader_byte_assembler #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   input  logic [1:0]       last_idx,
   output logic             word_valid,
   output logic [WIDTH-1:0] word
);

   logic [1:0]       byte_cnt;
   logic [WIDTH-1:0] shreg;

   // The completed word is presented in the same cycle its last byte arrives.
   assign word       = {byte_data, shreg[WIDTH-1:8]};
   assign word_valid = byte_valid && (byte_cnt == last_idx);

   // Shift bytes in from the top so the first byte ends up in bits [7:0].
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         byte_cnt <= '0;
         shreg    <= '0;
      end else if (byte_valid) begin
         shreg    <= word;
         byte_cnt <= word_valid ? 2'd0 : byte_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Fills instrmem from a framed byte stream and holds the CPU in reset until
// a load with a matching checksum completes.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter int          DEPTH     = 1024,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic             imem_we,
   output logic [WIDTH-1:0] imem_addr,
   output logic [WIDTH-1:0] imem_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int IDX_W = $clog2(DEPTH) + 1;

   state_t           state, state_nxt;
   logic             xfer;
   logic             start_ok;
   logic             word_valid;
   logic [WIDTH-1:0] asm_word;
   logic [WIDTH-1:0] n_words;
   logic [IDX_W-1:0] index;
   logic [7:0]       sum;

   // Ready depends only on state, which keeps the byte handshake free of
   // combinational loops through the assembler.
   assign rx_ready = (state == HDR) || (state == DATA) || (state == CSUM);
   assign xfer     = rx_valid && rx_ready;
   assign start_ok = start && (state == IDLE);

   prog_loader_byte_assembler #(.WIDTH(WIDTH)) u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .byte_valid (xfer),
      .byte_data  (rx_data),
      .last_idx   (last_byte_idx(state)),
      .word_valid (word_valid),
      .word       (asm_word)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      state_nxt = state;
      imem_we   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = HDR;
         HDR: begin
            busy = 1'b1;
            if (word_valid) begin
               if (asm_word == '0)                 state_nxt = CSUM;
               else if (asm_word > WIDTH'(DEPTH))  state_nxt = ERR;
               else                                state_nxt = DATA;
            end
         end
         DATA: begin
            busy = 1'b1;
            if (word_valid) state_nxt = WRITE;
         end
         WRITE: begin
            busy    = 1'b1;
            imem_we = 1'b1;
            if ((WIDTH'(index) + WIDTH'(1)) < n_words) state_nxt = DATA;
            else                                       state_nxt = CSUM;
         end
         CSUM: begin
            busy = 1'b1;
            if (xfer) state_nxt = (rx_data == sum) ? DONE : ERR;
         end
         DONE:    begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Load bookkeeping: word count, index, checksum, write port and status.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_words    <= '0;
         index      <= '0;
         sum        <= '0;
         imem_addr  <= WIDTH'(BASE_ADDR);
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         error      <= 1'b0;
      end else begin
         if (start_ok) begin
            index    <= '0;
            sum      <= '0;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
         end
         if (state == HDR && word_valid) n_words <= asm_word;
         if (state == DATA && xfer) sum <= sum + rx_data;
         // Address and data are staged with the last byte so they are
         // already stable in the WRITE cycle.
         if (state == DATA && word_valid) begin
            imem_addr  <= WIDTH'(BASE_ADDR) + WIDTH'(index) * WIDTH'(BYTES_PER_WORD);
            imem_wdata <= asm_word;
         end
         if (state == WRITE) index <= index + IDX_W'(1);
         if (state == DONE) cpu_hold <= 1'b0;
         if (state_nxt == ERR) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand sequences for
// reset/abort, and random frames checked against a frame-level model.
module tb_prog_loader;

   localparam int          DEPTH = 1024;
   localparam int unsigned BASE  = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready, imem_we, cpu_hold, busy, done, error;
   logic [31:0] imem_addr, imem_wdata;

   prog_loader #(.WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Observed activity, sampled on the falling edge.
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          done_cnt;
   int          stall_cnt;
   logic        hold_at_done, hold_after_done, prev_done;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
      if (busy && !rx_ready) stall_cnt++;
      if (prev_done) hold_after_done = cpu_hold;
      if (done) begin
         done_cnt++;
         hold_at_done = cpu_hold;
      end
      prev_done = done;
   end

   logic [31:0] fw [DEPTH];

   typedef struct {
      logic [31:0] n;
      logic [31:0] w0, w1, w2;
      logic [7:0]  csum;
      bit          auto_csum;
      int          gap;
      bit          mid_start;
      int          exp_writes;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   vec_t vt [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt        = 0;
      stall_cnt       = 0;
      hold_at_done    = 1'b0;
      hold_after_done = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w        = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      while (!rx_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!rx_ready) begin
         total++;
         bad++;
         $display("FAIL byte_timeout: rx_ready=%0b, required 1", rx_ready);
      end
      @(posedge clk);
      #2;
      rx_valid = 1'b0;
   endtask

   task automatic idle_gap(input int gap, input bit rnd);
      int g;
      g = rnd ? int'($urandom_range(gap, 0)) : gap;
      repeat (g) tick();
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk);
      while (busy && w < 100) begin
         w++;
         @(negedge clk);
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL busy_timeout: busy=%0b, required 0", busy);
      end
   endtask

   function automatic logic [7:0] frame_sum(input logic [31:0] n);
      logic [7:0] s;
      s = 8'h00;
      if (n <= DEPTH)
         for (int i = 0; i < int'(n); i++)
            for (int b = 0; b < 4; b++) s = s + fw[i][8*b +: 8];
      return s;
   endfunction

   // Frame-level expectations: accepted words land at consecutive word
   // addresses; success iff size fits and checksum matches the data bytes.
   task automatic model_check(input logic [31:0] n, input logic [7:0] cs);
      int nw;
      bit ok;
      nw = (n > DEPTH) ? 0 : int'(n);
      ok = (n <= DEPTH) && (frame_sum(n) == cs);
      check("write_count", 32'(wr_addr_q.size()), 32'(nw));
      for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
         check($sformatf("waddr[%0d]", i), wr_addr_q[i], 32'(BASE) + 32'(4 * i));
         check($sformatf("wdata[%0d]", i), wr_data_q[i], fw[i]);
      end
      check("done_pulses", 32'(done_cnt), 32'(ok));
      check("error", 32'(error), 32'(!ok));
      check("cpu_hold", 32'(cpu_hold), 32'(!ok));
      check("stall_cycles", 32'(stall_cnt), 32'(nw));
      if (ok) begin
         check("hold_at_done", 32'(hold_at_done), 32'd1);
         check("hold_after_done", 32'(hold_after_done), 32'd0);
      end
   endtask

   task automatic run_frame(input logic [31:0] n, input logic [7:0] cs, input int gap,
                            input bit rnd_gap, input bit mid_start);
      clear_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_byte(n[8*i +: 8]);
         idle_gap(gap, rnd_gap);
      end
      if (n > DEPTH) begin
         check("err_after_hdr", 32'(error), 32'd1);
         check("ready_in_err", 32'(rx_ready), 32'd0);
         check("hold_in_err", 32'(cpu_hold), 32'd1);
      end else begin
         for (int i = 0; i < int'(n); i++)
            for (int b = 0; b < 4; b++) begin
               if (mid_start && i == 0 && b == 1) start = 1'b1;
               send_byte(fw[i][8*b +: 8]);
               start = 1'b0;
               idle_gap(gap, rnd_gap);
            end
         send_byte(cs);
      end
      wait_idle();
      tick();
      tick();
      model_check(n, cs);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] n;
      logic [7:0]  cs;

      vt[0] = '{32'd2, 32'h00500093, 32'h00100113, 32'h0, 8'h07, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0};
      vt[1] = '{32'd0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0};
      vt[2] = '{32'd1025, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1};
      vt[3] = '{32'd1, 32'h11223344, 32'h0, 32'h0, 8'hAB, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1};
      vt[4] = '{32'd3, 32'hDEADBEEF, 32'h01020304, 32'hFFFFFFFF, 8'h3E, 1'b0, 1, 1'b1, 3, 1'b1, 1'b0};
      vt[5] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 8'hF8, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0};
      vt[6] = '{32'd1024, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 8'h00, 1'b1, 0, 1'b0, 1024, 1'b1, 1'b0};
      vt[7] = '{32'd0, 32'h0, 32'h0, 32'h0, 8'h01, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1};

      clear_mon();
      prev_done = 1'b0;
      tick();
      tick();
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_imem_addr", imem_addr, 32'(BASE));
      check("rst_imem_wdata", imem_wdata, 32'h0);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) begin
         fw[0] = vt[k].w0;
         fw[1] = vt[k].w1;
         fw[2] = vt[k].w2;
         if (vt[k].n <= DEPTH)
            for (int i = 3; i < int'(vt[k].n); i++) fw[i] = 32'(i) * 32'h9E3779B9;
         cs = vt[k].auto_csum ? frame_sum(vt[k].n) : vt[k].csum;
         run_frame(vt[k].n, cs, vt[k].gap, 1'b0, vt[k].mid_start);
         check($sformatf("tbl%0d_writes", k), 32'(wr_addr_q.size()), 32'(vt[k].exp_writes));
         check($sformatf("tbl%0d_done", k), 32'(done_cnt), 32'(vt[k].exp_done));
         check($sformatf("tbl%0d_error", k), 32'(error), 32'(vt[k].exp_err));
      end

      // Abort mid-load with reset, then reload cleanly.
      clear_mon();
      fw[0] = 32'hA5A55A5A;
      fw[1] = 32'h0BADC0DE;
      n = 32'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
      for (int i = 0; i < 6; i++) send_byte(fw[i / 4][8*(i % 4) +: 8]);
      check("pre_rst_writes", 32'(wr_addr_q.size()), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      tick();
      check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
      check("abort_rx_ready", 32'(rx_ready), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_error", 32'(error), 32'd0);
      check("abort_imem_we", 32'(imem_we), 32'd0);
      check("abort_imem_addr", imem_addr, 32'(BASE));
      check("abort_imem_wdata", imem_wdata, 32'h0);
      rst = 1'b0;
      tick();
      fw[0] = 32'hCAFEF00D;
      run_frame(32'd1, 8'hC5, 0, 1'b0, 1'b0);

      // Random frames with random gaps, occasional bad checksum or oversize.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(9, 0) == 0) n = 32'(DEPTH + 1) + 32'($urandom_range(100, 0));
         else                           n = 32'($urandom_range(6, 0));
         if (n <= DEPTH)
            for (int i = 0; i < int'(n); i++) fw[i] = $urandom;
         cs = frame_sum(n);
         if ($urandom_range(3, 0) == 0) cs = cs + 8'($urandom_range(255, 1));
         run_frame(n, cs, 2, 1'b1, 1'($urandom_range(1, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
